byte_to_symbol_buf: RTL

Parametrised byte-to-symbol converter for the DVB-C QAM mapper path. It accepts MPEG-TS bytes and emits MSB-first symbols of runtime-selectable width, from 2 up to MAX_M bits. Both sides use ready/valid handshakes, and a small output FIFO absorbs mapper back-pressure. It sits between the RS/interleaver output and the differential encoder/QAM mapper.

---
 rtl/bts_pkg.sv | 25 ++
 rtl/bts_sym_fifo.sv | 77 +++++++
 rtl/byte_to_symbol_buf.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bts_pkg.sv
// rtl/bts_pkg.sv - shared constants, mode clamp and symbol entry type for byte_to_symbol_buf
// Optional feature macro: BTS_SYNC_MARK_EN (adds the sync flag to sym_t users)
package bts_pkg;

    localparam int BTS_MIN_M = 2;
    localparam int BTS_MAX_M = 8;

    // One FIFO entry at the default symbol width: payload plus sync flag.
    typedef struct packed {
        logic                 sync;
        logic [BTS_MAX_M-1:0] data;
    } sym_t;

    // Bring an out-of-range bits-per-symbol request back into 2..max_m.
    function automatic logic [3:0] clamp_mode(input logic [3:0] mode, input int max_m);
        if (int'(mode) < BTS_MIN_M) begin
            return 4'(BTS_MIN_M);
        end
        if (int'(mode) > max_m) begin
            return 4'(max_m);
        end
        return mode;
    endfunction

endpackage

// File: rtl/bts_sym_fifo.sv
// rtl/bts_sym_fifo.sv - DEPTH-entry synchronous symbol FIFO with occupancy output
// Ports:
//   iClk, iClrn      clock, asynchronous active-low reset
//   iWrEn, iWrData   write strobe and entry (ignored while full)
//   iRdEn            pop strobe (ignored while empty)
//   oRdData          head entry, read combinationally from registered storage
//   oFull            level == DEPTH
//   oLevel           number of stored entries
module bts_sym_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       iClk,
    input  logic                       iClrn,
    input  logic                       iWrEn,
    input  logic [W-1:0]               iWrData,
    input  logic                       iRdEn,
    output logic [W-1:0]               oRdData,
    output logic                       oFull,
    output logic [$clog2(DEPTH):0]     oLevel
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             wr_ok, rd_ok;

    always_comb begin
        oFull   = (level_q == LVL_W'(DEPTH));
        oLevel  = level_q;
        oRdData = mem_q[rd_ptr_q];

        wr_ok = iWrEn && !oFull;
        rd_ok = iRdEn && (level_q != '0);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (wr_ok) begin
            mem_d[wr_ptr_q] = iWrData;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/byte_to_symbol_buf.sv
// rtl/byte_to_symbol_buf.sv - MPEG-TS byte to MSB-first QAM symbol converter with output FIFO
// Optional feature macro: BTS_SYNC_MARK_EN (flags the symbol holding the MSB of a sync byte)
// Ports:
//   iClk, iClrn              clock, asynchronous active-low reset
//   iMode                    bits per symbol request (clamped to 2..MAX_M, latched when empty)
//   iValid, iData, iPSync    input byte handshake, byte, packet-start marker
//   oReady                   a byte can be accepted this cycle
//   oValid, iReady           output symbol handshake
//   oData                    right-aligned symbol, upper bits zero
//   oSync                    symbol carries the first bit of a sync byte
//   oLevel                   FIFO occupancy
module byte_to_symbol_buf
    import bts_pkg::*;
#(
    parameter int MAX_M = 8,
    parameter int DEPTH = 4,
    parameter int ACC_W = MAX_M + 7
) (
    input  logic                       iClk,
    input  logic                       iClrn,
    input  logic [3:0]                 iMode,
    input  logic                       iValid,
    input  logic [7:0]                 iData,
    input  logic                       iPSync,
    output logic                       oReady,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [MAX_M-1:0]           oData,
    output logic                       oSync,
    output logic [$clog2(DEPTH):0]     oLevel
);

    localparam int CNT_W = $clog2(ACC_W + 1);
`ifdef BTS_SYNC_MARK_EN
    localparam int ENT_W = MAX_M + 1;
`else
    localparam int ENT_W = MAX_M;
`endif

    // Valid bits are kept left-aligned in acc_q: the oldest bit is acc_q[ACC_W-1].
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mode_q, mode_d;

    logic [ACC_W-1:0] acc_mid;
    logic [CNT_W-1:0] cnt_mid;
    logic [ACC_W-1:0] byte_ext;
    logic [MAX_M-1:0] sym;
    logic             accept;
    logic             extract;
    logic             fifo_full;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;
    logic             rd_en;

    always_comb begin
        // Readiness looks only at the current count, not at a same-cycle extract.
        oReady  = (int'(cnt_q) + 8 <= ACC_W);
        accept  = iValid && oReady;
        extract = (int'(cnt_q) >= int'(mode_q)) && !fifo_full;

        sym = acc_q[ACC_W-1 -: MAX_M] >> (MAX_M - int'(mode_q));

        // Extract first, then append the new byte right below whatever remains.
        acc_mid  = extract ? (acc_q << mode_q) : acc_q;
        cnt_mid  = extract ? (cnt_q - CNT_W'(mode_q)) : cnt_q;
        byte_ext = {{(ACC_W-8){1'b0}}, iData};

        acc_d  = acc_mid;
        cnt_d  = cnt_mid;
        mode_d = mode_q;
        if (accept) begin
            acc_d = acc_mid | (byte_ext << (ACC_W - 8 - int'(cnt_mid)));
            cnt_d = cnt_mid + CNT_W'(8);
            // Width changes only take effect on a symbol boundary of an empty accumulator.
            if (cnt_q == '0) begin
                mode_d = clamp_mode(iMode, MAX_M);
            end
        end
    end

    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 4'(MAX_M);
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

`ifdef BTS_SYNC_MARK_EN
    // sync_pos_q: offset of the pending sync MSB from the top of the accumulator.
    logic             sync_pend_q, sync_pend_d;
    logic [CNT_W-1:0] sync_pos_q, sync_pos_d;
    logic             sync_hit;

    always_comb begin
        sync_hit    = extract && sync_pend_q && (int'(sync_pos_q) < int'(mode_q));
        sync_pend_d = sync_pend_q;
        sync_pos_d  = sync_pos_q;
        if (extract && sync_pend_q) begin
            if (sync_hit) begin
                sync_pend_d = 1'b0;
            end else begin
                sync_pos_d = sync_pos_q - CNT_W'(mode_q);
            end
        end
        // A newer sync byte replaces one that has not been emitted yet.
        if (accept && iPSync) begin
            sync_pend_d = 1'b1;
            sync_pos_d  = cnt_mid;
        end
        wr_entry = {sync_hit, sym};
        oSync    = rd_entry[MAX_M];
    end

    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            sync_pend_q <= 1'b0;
            sync_pos_q  <= '0;
        end else begin
            sync_pend_q <= sync_pend_d;
            sync_pos_q  <= sync_pos_d;
        end
    end
`else
    logic unused_psync;

    always_comb begin
        unused_psync = iPSync;
        wr_entry     = sym;
        oSync        = 1'b0;
    end
`endif

    always_comb begin
        oValid = (oLevel != '0);
        rd_en  = oValid && iReady;
        oData  = rd_entry[MAX_M-1:0];
    end

    bts_sym_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .iClk    (iClk),
        .iClrn   (iClrn),
        .iWrEn   (extract),
        .iWrData (wr_entry),
        .iRdEn   (rd_en),
        .oRdData (rd_entry),
        .oFull   (fifo_full),
        .oLevel  (oLevel)
    );

endmodule
